// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port: req/addr out, gnt/rvalid/rdata back.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front end: PC, single-outstanding imem port, IF/ID output register,
// stall hold and redirect flush with stale-response dropping.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                redirect,
  input  logic [31:0]         redirect_target,
  input  logic                stall,
  output logic [31:0]         instruction_fetch,
  output logic [31:0]         pc_pre_address,
  output logic                fetch_valid
);

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_out;
  logic        grant, load, fv_n;

  // A new request only goes out when the output slot is free or drains this cycle.
  assign imem.req  = (state == REQ) & ~rst & ~redirect & (~fetch_valid | ~stall);
  assign imem.addr = pc;
  assign grant     = imem.req & imem.gnt;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    fv_n    = fetch_valid;
    case (state)
      REQ: begin
        if (grant) begin
          state_n = WAIT;
          pc_n    = pc + 32'd4;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          state_n = REQ;
          load    = ~redirect;
        end else if (redirect) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (imem.rvalid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    if (redirect) pc_n = redirect_target & 32'hFFFF_FFFC;

    // Flush beats load, load beats consumption.
    if (redirect)                  fv_n = 1'b0;
    else if (load)                 fv_n = 1'b1;
    else if (fetch_valid & ~stall) fv_n = 1'b0;
  end

  // Control and IF/ID output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= REQ;
      pc                <= RESET_PC;
      fetch_valid       <= 1'b0;
      instruction_fetch <= 32'h0;
      pc_pre_address    <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fetch_valid <= fv_n;
      if (load) begin
        instruction_fetch <= imem.rdata;
        pc_pre_address    <= pc_out;
      end
    end
  end

  // Address of the outstanding request
  always_ff @(posedge clk) begin
    if (grant) pc_out <= pc;
  end

endmodule
